instruction_fetch: RTL

- Fetch stage that sits directly upstream of instruction_memory and feeds decode.
- Owns the PC and drives the word address into the combinational instruction memory.
- Captures the returned instruction together with its PC into a small fetch FIFO.
- Presents {pc, instr} to decode over a valid/ready handshake; a redirect from execute (branch, jump or trap) flushes the FIFO and restarts fetch.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/instruction_fetch.sv | 88 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the fetch front end.
// Contents: datapath widths, PC increment, default reset PC, canonical NOP,
// and the fetch-queue entry layout {pc, instr}.
package riscv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [XLEN-1:0]    PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] INSTR_NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = XLEN + INSTR_W;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch queue.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   push, din    write request and data; ignored when full unless popping too
//   pop          read request; ignored when empty
//   flush        empties the queue; overrides push and pop
//   dout         head entry, zero while empty
//   full, empty  occupancy flags
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = FETCH_ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // Full-and-popping may still write: the freed slot is the one being overwritten.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q[AW-1:0]] = din;
                wptr_d                = wptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rptr_d = rptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the combinational instruction memory, queues
// {pc, instr} and hands entries to decode over valid/ready. A redirect flushes
// the queue and restarts fetch at the word-aligned target.
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   imem_addr / imem_instr       instruction memory address (= pc) and returned word
//   redirect_valid / redirect_pc restart request and target byte address
//   if_valid / if_ready          decode handshake
//   if_pc / if_instr             head entry presented to decode
//   misaligned_err               pulse the cycle after a redirect with target[1:0] != 0
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [XLEN-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               misaligned_err
);

    logic [XLEN-1:0]          pc_q, pc_d;
    logic                     misaligned_err_q, misaligned_err_d;
    logic                     fifo_full, fifo_empty;
    logic                     deq, enq;
    fetch_entry_t             push_entry, head_entry;
    logic [FETCH_ENTRY_W-1:0] fifo_din, fifo_dout;

    assign imem_addr = pc_q;

    // The head is hidden during a redirect so nothing stale is consumed.
    assign if_valid = !fifo_empty && !redirect_valid;
    assign deq      = if_valid && if_ready;
    assign enq      = !redirect_valid && (!fifo_full || deq);

    assign push_entry = '{pc: pc_q, instr: imem_instr};
    assign fifo_din   = push_entry;
    assign head_entry = fifo_dout;
    assign if_pc      = head_entry.pc;
    assign if_instr   = head_entry.instr;

    assign misaligned_err = misaligned_err_q;

    always_comb begin
        pc_d             = pc_q;
        misaligned_err_d = 1'b0;
        if (redirect_valid) begin
            pc_d             = {redirect_pc[XLEN-1:2], 2'b00};
            misaligned_err_d = |redirect_pc[1:0];
        end else if (enq) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            misaligned_err_q <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            misaligned_err_q <= misaligned_err_d;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(FETCH_ENTRY_W)
    ) u_fetch_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (enq),
        .pop  (deq),
        .flush(redirect_valid),
        .din  (fifo_din),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

endmodule
